// File: rtl/bbox_scan_ctrl.sv
// Bounding-box scan controller: captures a triangle, clamps its bounding box to
// the tile, then emits every pixel of the half-open box in row-major order.
module bbox_scan_ctrl #(
  parameter int          TILE_MIN_X  = 0,
  parameter int          TILE_MAX_X  = 32,
  parameter int          TILE_MIN_Y  = 0,
  parameter int          TILE_MAX_Y  = 16,
  parameter int unsigned COORD_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tri_valid,
  output logic                          tri_ready,
  input  logic signed [COORD_WIDTH-1:0] x0,
  input  logic signed [COORD_WIDTH-1:0] y0,
  input  logic signed [COORD_WIDTH-1:0] x1,
  input  logic signed [COORD_WIDTH-1:0] y1,
  input  logic signed [COORD_WIDTH-1:0] x2,
  input  logic signed [COORD_WIDTH-1:0] y2,
  output logic                          px_valid,
  input  logic                          px_ready,
  output logic signed [COORD_WIDTH-1:0] px_x,
  output logic signed [COORD_WIDTH-1:0] px_y,
  output logic                          px_last,
  output logic                          busy,
  output logic                          done
);

  // One guard bit so max-1 and cur+1 never wrap at the coordinate extremes.
  localparam int unsigned EW = COORD_WIDTH + 1;

  localparam logic signed [EW-1:0] TMIN_X = EW'(TILE_MIN_X);
  localparam logic signed [EW-1:0] TMAX_X = EW'(TILE_MAX_X);
  localparam logic signed [EW-1:0] TMIN_Y = EW'(TILE_MIN_Y);
  localparam logic signed [EW-1:0] TMAX_Y = EW'(TILE_MAX_Y);
  localparam logic signed [EW-1:0] ONE    = EW'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

  state_t r_state;
  state_t w_next;

  logic signed [EW-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic signed [EW-1:0] r_cur_x, r_cur_y;
  logic signed [EW-1:0] r_min_x, r_max_x, r_max_y;
  logic                 r_px_valid, r_busy, r_done;

  logic signed [EW-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
  logic signed [EW-1:0] w_inc_x;
  logic                 w_box_ok, w_hs, w_px_last;

  function automatic logic signed [EW-1:0] smin(input logic signed [EW-1:0] a,
                                                input logic signed [EW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [EW-1:0] smax(input logic signed [EW-1:0] a,
                                                input logic signed [EW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Bounding box of the captured vertices, clamped to the tile.
  assign w_min_x  = smax(smin(smin(r_x0, r_x1), r_x2), TMIN_X);
  assign w_max_x  = smin(smax(smax(r_x0, r_x1), r_x2), TMAX_X);
  assign w_min_y  = smax(smin(smin(r_y0, r_y1), r_y2), TMIN_Y);
  assign w_max_y  = smin(smax(smax(r_y0, r_y1), r_y2), TMAX_Y);
  assign w_box_ok = (w_min_x < w_max_x) && (w_min_y < w_max_y);

  assign w_hs      = (r_state == SCAN) && px_ready;
  assign w_inc_x   = r_cur_x + ONE;
  assign w_px_last = (r_state == SCAN) &&
                     (r_cur_x == r_max_x - ONE) && (r_cur_y == r_max_y - ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (tri_valid) w_next = SETUP;
      SETUP:   w_next = w_box_ok ? SCAN : IDLE;
      SCAN:    if (w_hs && w_px_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Vertex capture, scan counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_min_x    <= '0;
      r_max_x    <= '0;
      r_max_y    <= '0;
      r_px_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_px_valid <= (w_next == SCAN);
      r_busy     <= (w_next != IDLE);
      unique case (r_state)
        IDLE: begin
          if (tri_valid) begin
            r_x0 <= EW'(x0);
            r_y0 <= EW'(y0);
            r_x1 <= EW'(x1);
            r_y1 <= EW'(y1);
            r_x2 <= EW'(x2);
            r_y2 <= EW'(y2);
          end
        end
        SETUP: begin
          if (w_box_ok) begin
            r_cur_x <= w_min_x;
            r_cur_y <= w_min_y;
            r_min_x <= w_min_x;
            r_max_x <= w_max_x;
            r_max_y <= w_max_y;
          end else begin
            r_done <= 1'b1;
          end
        end
        SCAN: begin
          if (w_hs) begin
            if (w_px_last) r_done <= 1'b1;
            if (w_inc_x < r_max_x) begin
              r_cur_x <= w_inc_x;
            end else begin
              r_cur_x <= r_min_x;
              r_cur_y <= r_cur_y + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tri_ready = (r_state == IDLE) && !rst;
  assign px_valid  = r_px_valid;
  assign px_x      = r_cur_x[COORD_WIDTH-1:0];
  assign px_y      = r_cur_y[COORD_WIDTH-1:0];
  assign px_last   = w_px_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Directed bench for bbox_scan_ctrl: hand-computed pixel lists per triangle,
// backpressure, held tri_valid and asynchronous reset in mid-scan.
module tb_bbox_scan_ctrl;

  localparam int unsigned CW = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 tri_valid = 1'b0;
  logic                 tri_ready;
  logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic                 px_valid;
  logic                 px_ready = 1'b1;
  logic signed [CW-1:0] px_x, px_y;
  logic                 px_last, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_x[$];
  int exp_y[$];

  bbox_scan_ctrl #(.COORD_WIDTH(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .x2        (x2),
    .y2        (y2),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_last   (px_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_px_valid"},  px_valid,  0);
    chk({tag, "_px_last"},   px_last,   0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_px_x"},      px_x,      0);
    chk({tag, "_px_y"},      px_y,      0);
    chk({tag, "_tri_ready"}, tri_ready, 0);
  endtask

  // Offers one triangle, then watches it until done (or until abort_at pixels
  // have been accepted, at which point reset is pulsed mid-scan).
  task automatic run_tri(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int ax2, input int ay2, input int stall_idx,
                         input int stall_len, input bit hold_valid, input int abort_at);
    int k, npix, first_k, done_k, last_hs_k, pres_stall, stall_left;
    bit fin, aborted;
    @(negedge clk);
    chk("idle_tri_ready", tri_ready, 1);
    x0 = CW'(ax0); y0 = CW'(ay0);
    x1 = CW'(ax1); y1 = CW'(ay1);
    x2 = CW'(ax2); y2 = CW'(ay2);
    tri_valid = 1'b1;
    @(posedge clk);
    #1;
    tri_valid = hold_valid;
    x0 = '1; y0 = '1; x1 = '1; y1 = '1; x2 = '1; y2 = '1;
    k = 0; npix = 0; first_k = -1; done_k = -1; last_hs_k = -1;
    pres_stall = 0; stall_left = stall_len; fin = 1'b0; aborted = 1'b0;
    while (!fin && k < 200) begin
      @(negedge clk);
      k++;
      if (abort_at >= 0 && npix == abort_at) begin
        #1 rst = 1'b1;
        #1 chk_reset_outputs("abort_async");
        @(posedge clk);
        #1 chk_reset_outputs("abort_held");
        @(negedge clk);
        rst = 1'b0;
        tri_valid = 1'b0;
        #1 chk("abort_no_done", done, 0);
        chk("abort_idle_ready", tri_ready, 1);
        fin = 1'b1;
        aborted = 1'b1;
      end else begin
        chk("no_valid_with_done", px_valid & done, 0);
        if (done) begin
          done_k = k;
          fin = 1'b1;
          tri_valid = 1'b0;
          chk("busy_at_done", busy, 0);
          chk("ready_at_done", tri_ready, 1);
        end else begin
          chk("busy_in_flight", busy, 1);
          if (hold_valid) chk("ready_while_busy", tri_ready, 0);
        end
        if (px_valid) begin
          if (first_k < 0) first_k = k;
          if (npix < exp_x.size()) begin
            chk($sformatf("px_x[%0d]", npix), px_x, exp_x[npix]);
            chk($sformatf("px_y[%0d]", npix), px_y, exp_y[npix]);
            chk($sformatf("px_last[%0d]", npix), px_last, int'(npix == exp_x.size() - 1));
          end else begin
            chk("extra_pixel", npix, exp_x.size());
          end
          if (npix == stall_idx) pres_stall++;
          if (npix == stall_idx && stall_left > 0) begin
            px_ready = 1'b0;
            stall_left--;
          end else begin
            px_ready = 1'b1;
            last_hs_k = k;
            npix++;
          end
        end else begin
          px_ready = 1'b1;
        end
      end
    end
    px_ready = 1'b1;
    chk("terminated", fin, 1);
    if (!aborted) begin
      chk("pixel_count", npix, exp_x.size());
      if (exp_x.size() > 0) begin
        chk("first_valid_latency", first_k, 2);
        chk("done_after_last", done_k - last_hs_k, 1);
      end else begin
        chk("no_pixels", first_k, -1);
        chk("done_latency", done_k, 2);
      end
      if (stall_len > 0) chk("stall_presentations", pres_stall, stall_len + 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    #1 chk_reset_outputs("reset_clk");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_reset_ready", tri_ready, 1);

    // Basic scan.
    exp_x = '{2, 3, 4, 2, 3, 4};
    exp_y = '{1, 1, 1, 2, 2, 2};
    run_tri(2, 1, 5, 1, 2, 3, -1, 0, 1'b0, -1);

    // Degenerate box.
    exp_x = {};
    exp_y = {};
    run_tri(7, 0, 7, 5, 7, 9, -1, 0, 1'b0, -1);

    // Entirely left of the tile.
    run_tri(-20, 2, -10, 3, -15, 8, -1, 0, 1'b0, -1);

    // Clamped to the bottom-right tile corner.
    exp_x = '{30, 31, 30, 31};
    exp_y = '{14, 14, 15, 15};
    run_tri(30, 14, 40, 14, 30, 20, -1, 0, 1'b0, -1);

    // Backpressure on (3,1) for three cycles.
    exp_x = '{2, 3, 4, 2, 3, 4};
    exp_y = '{1, 1, 1, 2, 2, 2};
    run_tri(2, 1, 5, 1, 2, 3, 1, 3, 1'b0, -1);

    // tri_valid held high through the whole triangle.
    run_tri(2, 1, 5, 1, 2, 3, -1, 0, 1'b1, -1);

    // Reset after two pixels, then a fresh triangle.
    run_tri(2, 1, 5, 1, 2, 3, -1, 0, 1'b0, 2);
    exp_x = '{1, 2, 1, 2};
    exp_y = '{0, 0, 1, 1};
    run_tri(1, 0, 3, 0, 1, 2, -1, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bbox_scan_ctrl.md
BBOX_SCAN_CTRL -- requirements
Module: bbox_scan_ctrl

Interface
REQ-001 The block SHALL have the parameter TILE_MIN_X, default 0: inclusive tile left edge (signed).
REQ-002 The block SHALL have the parameter TILE_MAX_X, default 32: exclusive tile right edge (signed).
REQ-003 The block SHALL have the parameter TILE_MIN_Y, default 0: inclusive tile top edge (signed).
REQ-004 The block SHALL have the parameter TILE_MAX_Y, default 16: exclusive tile bottom edge (signed).
REQ-005 The block SHALL have the parameter COORD_WIDTH, default 10: width of every coordinate port.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 tri_valid  in  1  triangle vertices present on x0..y2.
REQ-009 tri_ready  out  1  block accepts a triangle this cycle.
REQ-010 x0, y0, x1, y1, x2, y2  in  COORD_WIDTH each, signed  screen-space vertex coordinates.
REQ-011 px_valid  out  1  pixel coordinate presented.
REQ-012 px_ready  in  1  downstream accepts the pixel.
REQ-013 px_x, px_y  out  COORD_WIDTH each, signed  current pixel coordinate.
REQ-014 px_last  out  1  the presented pixel is the final pixel of the triangle.
REQ-015 busy  out  1  a triangle is held (state not IDLE).
REQ-016 done  out  1  one-cycle pulse marking the end of a triangle.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, SETUP and SCAN, each with a registered state register.
REQ-018 The block SHALL drive tri_ready = 1 only in IDLE with rst low.
- On tri_valid & tri_ready at cycle N, the block SHALL register all six vertex inputs and enter SETUP at N+1.
REQ-019 In SETUP the block SHALL compute the bounding box from the registered vertices.
- i_min/i_max SHALL be the min/max over the three vertices per axis (signed compare).
- min SHALL be clamped up to TILE_MIN; max SHALL be clamped down to TILE_MAX.
- The box SHALL be valid iff min_x < max_x and min_y < max_y.
REQ-020 SETUP with a valid box SHALL load cur_x = min_x and cur_y = min_y, latch min_x, max_x and max_y, and enter SCAN; the first px_valid SHALL therefore appear at N+2.
REQ-021 SETUP with an invalid box SHALL enter IDLE and pulse done at N+2, and SHALL emit no pixels.
REQ-022 The scan range SHALL be half-open, x in [min_x, max_x) and y in [min_y, max_y), traversed row-major with x fastest.
REQ-023 In SCAN the block SHALL drive px_valid = 1, px_x = cur_x and px_y = cur_y.
- While px_ready = 0, px_x, px_y and px_last SHALL hold stable.
REQ-024 On px_valid & px_ready:
- if cur_x + 1 < max_x, the block SHALL increment cur_x;
- otherwise it SHALL set cur_x = min_x and increment cur_y.
REQ-025 The block SHALL assert px_last combinationally when cur_x = max_x - 1 and cur_y = max_y - 1.
- The handshake of that pixel SHALL return the FSM to IDLE and pulse done in the following cycle.
- tri_ready SHALL be 1 in that same cycle.
REQ-026 Internal counters and comparisons SHALL use COORD_WIDTH+1-bit signed arithmetic so that max - 1 and cur + 1 never wrap.
REQ-027 tri_valid SHALL be ignored outside IDLE; vertex inputs SHALL be sampled only on acceptance.
REQ-028 busy SHALL be 1 in SETUP and SCAN; done SHALL be registered and never coincide with px_valid.

Reset
REQ-029 Assertion of rst SHALL immediately force state = IDLE, with px_valid, px_last, busy, done, px_x and px_y = 0 and tri_ready = 0, independent of clk.
REQ-030 Assertion of rst mid-SCAN SHALL abandon the triangle without a done pulse.
- After rst deasserts, the next accepted triangle SHALL scan from its own min corner.

Verification
REQ-031 Basic scan: verts (2,1),(5,1),(2,3), default tile, px_ready=1 -> pixels in order (2,1),(3,1),(4,1),(2,2),(3,2),(4,2); px_last only on (4,2); done one cycle later; first px_valid 2 cycles after acceptance.
REQ-032 Degenerate box: verts (7,0),(7,5),(7,9) -> zero px_valid cycles; done pulses 2 cycles after acceptance.
REQ-033 Off-tile clamping: verts (-20,2),(-10,3),(-15,8) -> max_x clamped to -10 < min_x 0, box invalid -> no pixels, done pulses; separately verts (30,14),(40,14),(30,20) -> pixels x in {30,31}, y in {14,15}, 4 pixels total.
REQ-034 Backpressure: basic scan with px_ready=0 for 3 cycles while (3,1) is presented -> (3,1) held stable for all 4 cycles, emitted exactly once, no pixel skipped or duplicated.
REQ-035 Reset mid-scan and overlap: rst pulsed after 2 pixels -> outputs zero asynchronously and no done; then a new triangle runs cleanly from its min corner; tri_valid held high during SCAN -> tri_ready=0 and no second capture until IDLE.
